// File: rtl/sub_seq_ctrl.sv
// Sequential multi-byte subtractor: one 8-bit ripple-borrow slice per cycle, LSB first.
// Define SUB_SEQ_SAT_EN to make the result saturate at zero on underflow.
module sub_seq_ctrl #(
    parameter int BYTES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [8*BYTES-1:0] a,
    input  logic [8*BYTES-1:0] b,
    input  logic               b_in,
    output logic               busy,
    output logic               done,
    output logic [8*BYTES-1:0] difference,
    output logic               borrow
);

    localparam int W  = 8 * BYTES;
    localparam int IW = $clog2(BYTES);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  diff_q, diff_d;
    logic          bin_q, bin_d;
    logic          bor_q, bor_d;
    logic          borrow_q, borrow_d;

    logic          sl_bin;
    logic [8:0]    sl_res;
    logic          last_slice;

    // Latched operands shift right each RUN cycle, so the active slice is always bits [7:0].
    assign sl_bin     = (idx_q == '0) ? bin_q : bor_q;
    assign sl_res     = {1'b0, a_q[7:0]} - {1'b0, b_q[7:0]} - {8'b0, sl_bin};
    assign last_slice = (idx_q == IW'(BYTES - 1));

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        diff_d   = diff_q;
        bin_d    = bin_q;
        bor_d    = bor_q;
        borrow_d = borrow_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    bin_d   = b_in;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 8;
                b_d   = b_q >> 8;
                acc_d = {sl_res[7:0], acc_q[W-1:8]};
                bor_d = sl_res[8];
                idx_d = idx_q + 1'b1;
                if (last_slice) begin
                    idx_d    = '0;
                    state_d  = DONE;
                    borrow_d = sl_res[8];
`ifdef SUB_SEQ_SAT_EN
                    diff_d   = sl_res[8] ? '0 : acc_d;
`else
                    diff_d   = acc_d;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; all of it, datapath included,
    // is cleared by reset so an aborted operation leaves nothing behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            diff_q   <= '0;
            bin_q    <= 1'b0;
            bor_q    <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            diff_q   <= diff_d;
            bin_q    <= bin_d;
            bor_q    <= bor_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign difference = diff_q;
    assign borrow     = borrow_q;

endmodule

// File: tb/tb_sub_seq_ctrl.sv
// Directed bench for sub_seq_ctrl (BYTES=4): vector table, back-to-back run, mid-RUN reset.
// Expected results follow SUB_SEQ_SAT_EN when the macro is defined for the build.
module tb_sub_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        b_in;
    logic        busy;
    logic        done;
    logic [31:0] difference;
    logic        borrow;

    int n_vec;
    int n_err;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [31:0] d;    // wrapped result
        logic        bo;   // borrow out
        string       name;
    } vec_t;

    vec_t vecs[8];

    sub_seq_ctrl #(.BYTES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .b_in       (b_in),
        .busy       (busy),
        .done       (done),
        .difference (difference),
        .borrow     (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_diff(input vec_t v);
`ifdef SUB_SEQ_SAT_EN
        return v.bo ? 32'h0 : v.d;
`else
        return v.d;
`endif
    endfunction

    // One operation; operands are scrambled right after the start edge and a start pulse
    // is injected mid-RUN, neither of which may influence the result.
    task automatic run_op(input vec_t v);
        int busy_cnt;
        int done_cnt;
        @(negedge clk);
        a = v.a; b = v.b; b_in = v.bin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; b_in = ~v.bin;
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            busy_cnt += int'(busy);
            done_cnt += int'(done);
            if (c == 1) start = 1'b1;
            if (c == 2) start = 1'b0;
            @(posedge clk); #1;
        end
        check({v.name, "_busy_cycles"}, 32'(busy_cnt), 32'd4);
        check({v.name, "_early_done"}, 32'(done_cnt), 32'd0);
        check({v.name, "_done"}, {31'b0, done}, 32'd1);
        check({v.name, "_busy_off"}, {31'b0, busy}, 32'd0);
        check({v.name, "_diff"}, difference, exp_diff(v));
        check({v.name, "_borrow"}, {31'b0, borrow}, {31'b0, v.bo});
        @(posedge clk); #1;
        check({v.name, "_done_pulse"}, {31'b0, done}, 32'd0);
        check({v.name, "_idle_busy"}, {31'b0, busy}, 32'd0);
        check({v.name, "_diff_hold"}, difference, exp_diff(v));
    endtask

    initial begin
        int dcnt;
        int bcnt;
        n_vec = 0;
        n_err = 0;

        vecs[0] = '{32'h12345678, 32'h00000001, 1'b0, 32'h12345677, 1'b0, "basic"};
        vecs[1] = '{32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 1'b0, "ripple"};
        vecs[2] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, "under"};
        vecs[3] = '{32'h00000005, 32'h00000005, 1'b1, 32'hFFFFFFFF, 1'b1, "eq_bin"};
        vecs[4] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'hFFFFFFFE, 1'b0, "max_bin"};
        vecs[5] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFE, 1'b0, "msb_rip"};
        vecs[6] = '{32'h00010000, 32'h0000FFFF, 1'b0, 32'h00000001, 1'b0, "mid_rip"};
        vecs[7] = '{32'hDEADBEEF, 32'h12345678, 1'b0, 32'hCC796877, 1'b0, "mixed"};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_diff", difference, 32'd0);
        check("rst_borrow", {31'b0, borrow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_op(vecs[i]);

        // Back-to-back: start held high, new operands presented right after each acceptance.
        @(negedge clk);
        a = vecs[0].a; b = vecs[0].b; b_in = vecs[0].bin; start = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("b2b%0d_busy", k), {31'b0, busy}, 32'd1);
            if (k == 0) begin
                a = vecs[6].a; b = vecs[6].b; b_in = vecs[6].bin;
            end else if (k == 1) begin
                a = vecs[7].a; b = vecs[7].b; b_in = vecs[7].bin;
            end else begin
                start = 1'b0; a = $urandom; b = $urandom;
            end
            repeat (4) @(posedge clk);
            #1;
            check($sformatf("b2b%0d_done", k), {31'b0, done}, 32'd1);
            check($sformatf("b2b%0d_diff", k), difference,
                  exp_diff(vecs[(k == 0) ? 0 : ((k == 1) ? 6 : 7)]));
            check($sformatf("b2b%0d_borrow", k), {31'b0, borrow}, 32'd0);
            @(posedge clk); #1;
        end
        check("b2b_end_idle", {30'b0, busy, done}, 32'd0);

        // Asynchronous reset during the second RUN cycle.
        @(negedge clk);
        a = vecs[7].a; b = vecs[7].b; b_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        check("mid_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_done", {31'b0, done}, 32'd0);
        check("arst_diff", difference, 32'd0);
        check("arst_borrow", {31'b0, borrow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        bcnt = 0;
        repeat (6) begin
            @(posedge clk); #1;
            dcnt += int'(done);
            bcnt += int'(busy);
        end
        check("arst_no_done", 32'(dcnt), 32'd0);
        check("arst_no_busy", 32'(bcnt), 32'd0);
        check("arst_diff_hold", difference, 32'd0);
        run_op(vecs[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
